// File: rtl/gpio_conditioner.sv
// gpio_conditioner: per-lane synchroniser + debounce, command-press arbitration and chunk-select guard.
// Build option: define GPIO_ACTIVE_LOW_EN to invert every pad before the synchroniser (pad low = pressed).
module gpio_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_gpio_raw,
  output logic [11:0] o_gpio,
  output logic        o_conflict
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // True when v has at most one bit set.
  function automatic logic onehot0_f(input logic [3:0] v);
    return ((v & (v - 4'd1)) == 4'd0);
  endfunction

  logic [11:0]      pad_s;
  logic [11:0]      s1_r;
  logic [11:0]      s2_r;
  logic [11:0]      db_r;
  logic [3:0]       cmd_db_q_r;
  logic [CNT_W-1:0] cnt_r [12];
  logic [3:0]       press_s;
  logic [3:0]       cmd_s;
  logic [3:0]       chunk_s;
  logic             conflict_s;

`ifdef GPIO_ACTIVE_LOW_EN
  assign pad_s = ~i_gpio_raw;
`else
  assign pad_s = i_gpio_raw;
`endif

  // Two-flop synchroniser on every lane.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_r <= 12'h000;
      s2_r <= 12'h000;
    end else begin
      s1_r <= pad_s;
      s2_r <= s1_r;
    end
  end

  // Debounce: db flips only after s2 disagrees for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_r <= 12'h000;
      for (int i = 0; i < 12; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (s2_r[i] == db_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          db_r[i]  <= s2_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Delayed copy of the command lanes for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_db_q_r <= 4'b0000;
    end else begin
      cmd_db_q_r <= db_r[11:8];
    end
  end

  // Press arbitration (STOP > REC > PLAY > MIX) and chunk-select one-hot guard.
  always_comb begin
    press_s    = db_r[11:8] & ~cmd_db_q_r;
    conflict_s = ~onehot0_f(press_s);
    cmd_s      = 4'b0000;
    if (press_s[0]) begin
      cmd_s = 4'b0001;
    end else if (press_s[3]) begin
      cmd_s = 4'b1000;
    end else if (press_s[2]) begin
      cmd_s = 4'b0100;
    end else if (press_s[1]) begin
      cmd_s = 4'b0010;
    end else begin
      cmd_s = 4'b0000;
    end
    if (onehot0_f(db_r[3:0])) begin
      chunk_s = db_r[3:0];
    end else begin
      chunk_s = 4'b0000;
    end
  end

  // Output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gpio     <= 12'h000;
      o_conflict <= 1'b0;
    end else begin
      o_gpio     <= {cmd_s, db_r[7:4], chunk_s};
      o_conflict <= conflict_s;
    end
  end

endmodule

// File: tb/tb_gpio_conditioner.sv
// tb_gpio_conditioner: table-driven stimulus with a per-cycle expectation scoreboard, plus a mid-debounce reset sequence.
module tb_gpio_conditioner;

  localparam int NC = 1000;
`ifdef GPIO_ACTIVE_LOW_EN
  localparam logic [11:0] IDLE_PADS = 12'hFFF;
`else
  localparam logic [11:0] IDLE_PADS = 12'h000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] gpio_raw;
  logic [11:0] gpio;
  logic        conflict;

  typedef struct {
    logic [11:0] raw;
    int          hold;
    logic [11:0] pre;
    logic [11:0] post;
    logic [11:0] pulse;
    logic        conf;
    int          chg;
  } vec_t;

  typedef struct {
    logic [11:0] gpio;
    logic        conf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  gpio_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_gpio_raw (gpio_raw),
    .o_gpio     (gpio),
    .o_conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] g, input logic c,
                       input logic [11:0] eg, input logic ec);
    n_total++;
    if (g === eg && c === ec) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got gpio=%03h conflict=%0b, expected gpio=%03h conflict=%0b", name, g, c, eg, ec);
    end
  endtask

  task automatic add(input logic [11:0] raw, input int hold, input logic [11:0] pre,
                     input logic [11:0] post, input logic [11:0] pulse, input logic conf, input int chg);
    vec_t v;
    v.raw = raw; v.hold = hold; v.pre = pre; v.post = post;
    v.pulse = pulse; v.conf = conf; v.chg = chg;
    vecs.push_back(v);
  endtask

  // Logical pad value (1 = pressed) is mapped onto the physical pad polarity.
  task automatic drive(input logic [11:0] logical);
    gpio_raw = logical ^ IDLE_PADS;
  endtask

  // Sample index j counts edges from the one that first captures the new input (j = 0).
  task automatic push_expect(input vec_t v);
    exp_t e;
    for (int j = 0; j < v.hold; j++) begin
      e.gpio = (j < v.chg) ? v.pre : v.post;
      e.conf = 1'b0;
      if (j == v.chg) begin
        e.gpio = e.gpio | v.pulse;
        e.conf = v.conf;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic run_cycles(input int n, input string tag);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL %s_cyc%0d: scoreboard empty, got gpio=%03h, required an expectation", tag, j, gpio);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s_cyc%0d", tag, j), gpio, conflict, e.gpio, e.conf);
      end
    end
  endtask

  initial begin
    vec_t v;
    gpio_raw = IDLE_PADS;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", gpio, conflict, 12'h000, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", gpio, conflict, 12'h000, 1'b0);

    //   raw      hold  pre      post     pulse    conf  chg
    add(12'h800, 50, 12'h000, 12'h000, 12'h800, 1'b0, 6);   // REC held: one pulse
    add(12'h000, 12, 12'h000, 12'h000, 12'h000, 1'b0, NC);  // release: nothing
    add(12'h400,  3, 12'h000, 12'h000, 12'h000, 1'b0, NC);  // 3-cycle glitch
    add(12'h000, 12, 12'h000, 12'h000, 12'h000, 1'b0, NC);
    add(12'h900, 20, 12'h000, 12'h000, 12'h100, 1'b1, 6);   // REC+STOP -> STOP
    add(12'h000, 12, 12'h000, 12'h000, 12'h000, 1'b0, NC);
    add(12'h600, 12, 12'h000, 12'h000, 12'h400, 1'b1, 6);   // PLAY+MIX -> PLAY
    add(12'h000, 12, 12'h000, 12'h000, 12'h000, 1'b0, NC);
    add(12'hC00, 12, 12'h000, 12'h000, 12'h800, 1'b1, 6);   // REC+PLAY -> REC
    add(12'h000, 12, 12'h000, 12'h000, 12'h000, 1'b0, NC);
    add(12'hF00, 12, 12'h000, 12'h000, 12'h100, 1'b1, 6);   // all four -> STOP
    add(12'h000, 12, 12'h000, 12'h000, 12'h000, 1'b0, NC);
    add(12'h100, 12, 12'h000, 12'h000, 12'h100, 1'b0, 6);   // STOP alone
    add(12'h000, 12, 12'h000, 12'h000, 12'h000, 1'b0, NC);
    add(12'h005, 12, 12'h000, 12'h000, 12'h000, 1'b0, NC);  // two chunks: guarded
    add(12'h004, 12, 12'h000, 12'h004, 12'h000, 1'b0, 6);   // drop bit 0
    add(12'h000, 12, 12'h004, 12'h000, 12'h000, 1'b0, 6);
    add(12'h0A0, 12, 12'h000, 12'h0A0, 12'h000, 1'b0, 6);   // level lanes
    add(12'h000, 12, 12'h0A0, 12'h000, 12'h000, 1'b0, 6);
    add(12'h212, 12, 12'h000, 12'h012, 12'h200, 1'b0, 6);   // MIX + levels together
    add(12'h000, 12, 12'h012, 12'h000, 12'h000, 1'b0, 6);
    add(12'h008, 12, 12'h000, 12'h008, 12'h000, 1'b0, 6);
    add(12'h000, 12, 12'h008, 12'h000, 12'h000, 1'b0, 6);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.raw);
      push_expect(v);
      run_cycles(v.hold, $sformatf("vec%0d", i));
    end

    // MIX pressed, reset lands after two debounce counts, released with the pin still high.
    drive(12'h200);
    push_expect('{raw: 12'h200, hold: 4, pre: 12'h000, post: 12'h000, pulse: 12'h000, conf: 1'b0, chg: NC});
    run_cycles(4, "rst_pre");
    rst_n = 1'b0;
    #1;
    check("rst_async", gpio, conflict, 12'h000, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold%0d", j), gpio, conflict, 12'h000, 1'b0);
    end
    #2 rst_n = 1'b1;
    push_expect('{raw: 12'h200, hold: 11, pre: 12'h000, post: 12'h000, pulse: 12'h200, conf: 1'b0, chg: 6});
    run_cycles(11, "rst_post");
    drive(12'h000);
    push_expect('{raw: 12'h000, hold: 12, pre: 12'h000, post: 12'h000, pulse: 12'h000, conf: 1'b0, chg: NC});
    run_cycles(12, "rst_release");

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL sb_leftover: got %0d entries, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
